mult_div_unit: RTL

- Iterative multiply/divide sequencer for the MIPS core; owns the HI/LO architectural registers.
- Executes MULT, MULTU, DIV and DIVU over 32 cycles, replacing the ALU's zero placeholders for signed multiply and divide/modulo.
- Services MFHI, MFLO, MTHI and MTLO, and raises a stall to the pipeline while busy.

---
 rtl/md_pkg.sv | 20 ++
 rtl/md_step.sv | 34 +++
 rtl/mult_div_unit.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package md_pkg;

  localparam int MD_WIDTH = 32;
  localparam logic [MD_WIDTH-1:0] DIV0_LO = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/md_step.sv
// One iteration of the shared 2*WIDTH accumulator: shift-add multiply or
// restoring divide ({remainder, dividend/quotient} shifted left).
module md_step
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic               i_div,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH-1:0] w_diff;
  logic             w_ok;

  always_comb begin
    w_sum    = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_opnd} : '0);
    w_rem_sh = i_acc[2*WIDTH-1:WIDTH-1];
    w_ok     = (w_rem_sh >= {1'b0, i_opnd});
    // A successful trial subtract always leaves a result below the divisor
    w_diff   = w_rem_sh[WIDTH-1:0] - i_opnd;
    if (!i_div) begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end else if (w_ok) begin
      o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {w_rem_sh[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// MIPS HI/LO owner: 32-cycle iterative MULT/MULTU/DIV/DIVU on unsigned
// magnitudes with a final sign fix-up, plus MTHI/MTLO and pipeline stall.
module mult_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  md_op_t           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int AW = 2 * WIDTH;

  function automatic logic signed [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] v);
    return -v;
  endfunction

  function automatic logic signed [AW-1:0] neg_dw(input logic signed [AW-1:0] v);
    return -v;
  endfunction

  md_state_t        r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_acc, w_acc_step, w_acc_init, w_prod;
  logic [WIDTH-1:0] r_opnd, r_a_orig, r_hi, r_lo, r_done_unused_guard;
  logic             r_is_div, r_neg_q, r_neg_r, r_div0, r_done;
  logic             w_accept, w_last, w_signed, w_is_div, w_sa, w_sb;
  logic [WIDTH-1:0] w_mag_a, w_mag_b, w_fix_hi, w_fix_lo, w_q, w_r;

  assign busy  = (r_state != IDLE);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;
  assign stall = busy & (start | mthi | mtlo | rd_req);

  assign w_accept = (r_state == IDLE) & start;
  assign w_last   = (r_cnt == CW'(ITER - 1));
  assign w_is_div = (op == MD_DIV) | (op == MD_DIVU);
  assign w_signed = (op == MD_MULT) | (op == MD_DIV);
  assign w_sa     = w_signed & a[WIDTH-1];
  assign w_sb     = w_signed & b[WIDTH-1];
  assign w_mag_a  = w_sa ? neg_w(a) : a;
  assign w_mag_b  = w_sb ? neg_w(b) : b;
  assign w_acc_init = {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};

  md_step #(.WIDTH(WIDTH)) u_step (
    .i_div  (r_is_div),
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_step)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = RUN;
      RUN:     if (w_last) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Operand capture and iteration datapath (no reset needed: always loaded on accept)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc    <= w_acc_init;
      r_opnd   <= w_is_div ? w_mag_b : w_mag_a;
      r_a_orig <= a;
      r_is_div <= w_is_div;
      r_neg_q  <= w_sa ^ w_sb;
      r_neg_r  <= w_sa;
      r_div0   <= w_is_div & (b == '0);
    end else if (r_state == RUN) begin
      r_acc <= w_acc_step;
    end
  end

  // Sign fix-up; divide-by-zero yields a fixed pattern rather than trapping
  always_comb begin
    w_prod   = r_neg_q ? neg_dw(r_acc) : r_acc;
    w_q      = r_acc[WIDTH-1:0];
    w_r      = r_acc[AW-1:WIDTH];
    w_fix_hi = w_prod[AW-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_fix_hi = r_a_orig;
        w_fix_lo = WIDTH'(DIV0_LO);
      end else begin
        w_fix_lo = r_neg_q ? neg_w(w_q) : w_q;
        w_fix_hi = r_neg_r ? neg_w(w_r) : w_r;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt <= '0;
          end else begin
            if (mthi) r_hi <= wdata;
            if (mtlo) r_lo <= wdata;
          end
        end
        RUN: r_cnt <= r_cnt + CW'(1);
        FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign r_done_unused_guard = '0;

endmodule
